// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the two source byte streams, the merged output stream and the
// arbitration status seen by the UART transmit path.
interface uart_tx_arbiter_if;
    logic [7:0] s0_data;
    logic       s0_vld;
    logic       s0_last;
    logic       s0_rdy;
    logic [7:0] s1_data;
    logic       s1_vld;
    logic       s1_last;
    logic       s1_rdy;
    logic [7:0] out_data;
    logic       out_vld;
    logic       out_rdy;
    logic [1:0] grant;
    logic       abort;

    modport slave (
        input  s0_data, s0_vld, s0_last,
        input  s1_data, s1_vld, s1_last,
        input  out_rdy,
        output s0_rdy, s1_rdy,
        output out_data, out_vld, grant, abort
    );

    modport master (
        output s0_data, s0_vld, s0_last,
        output s1_data, s1_vld, s1_last,
        output out_rdy,
        input  s0_rdy, s1_rdy,
        input  out_data, out_vld, grant, abort
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin framer merging two byte sources onto one UART byte stream:
// each frame is wrapped as tag header, payload, then EOF or abort trailer.
module uart_tx_arbiter #(
    parameter logic [7:0]  P_TAG_BASE   = 8'h30,
    parameter logic [7:0]  P_EOF_BYTE   = 8'h0A,
    parameter logic [7:0]  P_ABORT_BYTE = 8'h21,
    parameter int unsigned P_TIMEOUT    = 1000
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus_if
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_e;

    localparam logic [15:0] TIMEOUT_C = 16'(P_TIMEOUT);

    state_e      state_q;
    logic [1:0]  grant_q;
    logic        rr_last_q;   // most recent grant; also owner of the frame in flight
    logic [7:0]  byte_q;      // header or trailer held stable while stalled
    logic        abort_q;
    logic [15:0] cnt_q;

    logic        pick_idx;
    logic [7:0]  sel_data;
    logic        sel_vld;
    logic        sel_last;
    logic        xfer;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        pick_idx = (bus_if.s0_vld && bus_if.s1_vld) ? ~rr_last_q : bus_if.s1_vld;
        sel_data = rr_last_q ? bus_if.s1_data : bus_if.s0_data;
        sel_vld  = rr_last_q ? bus_if.s1_vld  : bus_if.s0_vld;
        sel_last = rr_last_q ? bus_if.s1_last : bus_if.s0_last;
        xfer     = sel_vld && bus_if.out_rdy;

        bus_if.out_data = 8'h00;
        bus_if.out_vld  = 1'b0;
        bus_if.s0_rdy   = 1'b0;
        bus_if.s1_rdy   = 1'b0;
        unique case (state_q)
            HDR, TRL: begin
                bus_if.out_vld  = 1'b1;
                bus_if.out_data = byte_q;
            end
            DATA: begin
                bus_if.out_vld  = sel_vld;
                bus_if.out_data = sel_data;
                bus_if.s0_rdy   = !rr_last_q && bus_if.out_rdy;
                bus_if.s1_rdy   =  rr_last_q && bus_if.out_rdy;
            end
            default: ;
        endcase
    end

    assign bus_if.grant = grant_q;
    assign bus_if.abort = abort_q;

    // NOTE: asynchronous reset drops any partial frame at once; the pointer
    // resets to source 1 so source 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            rr_last_q <= 1'b1;
            byte_q    <= 8'h00;
            abort_q   <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus_if.s0_vld || bus_if.s1_vld) begin
                        rr_last_q <= pick_idx;
                        grant_q   <= pick_idx ? 2'b10 : 2'b01;
                        byte_q    <= P_TAG_BASE + {7'd0, pick_idx};
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    if (bus_if.out_rdy) begin
                        cnt_q   <= 16'd0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        cnt_q <= 16'd0;
                        if (sel_last) begin
                            byte_q  <= P_EOF_BYTE;
                            state_q <= TRL;
                        end
                    end else if (!sel_vld) begin
                        // Stalls by the sink with a byte pending do not age the frame.
                        if (cnt_q + 16'd1 == TIMEOUT_C) begin
                            cnt_q   <= 16'd0;
                            byte_q  <= P_ABORT_BYTE;
                            abort_q <= 1'b1;
                            state_q <= TRL;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                end
                TRL: begin
                    if (bus_if.out_rdy) begin
                        grant_q <= 2'b00;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: source queues feed frames, the merged
// output stream, grant sequence and abort pulses are compared to hand values.
module tb_uart_tx_arbiter;

    logic clk;
    logic rst;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .P_TAG_BASE  (8'h30),
        .P_EOF_BYTE  (8'h0A),
        .P_ABORT_BYTE(8'h21),
        .P_TIMEOUT   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] s0_q[$];
    logic [8:0] s1_q[$];
    logic [7:0] out_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] grant_q[$];
    logic [1:0] exp_g[$];

    int         cyc_n;
    int         first_x;
    int         last_x;
    int         abort_n;
    bit         toggle_rdy;
    bit         stall_prev;
    logic [7:0] stall_data;
    logic [1:0] grant_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.s0_vld = (s0_q.size() != 0);
        if (bus.s0_vld) {bus.s0_last, bus.s0_data} = s0_q[0];
        else            {bus.s0_last, bus.s0_data} = 9'h000;
        bus.s1_vld = (s1_q.size() != 0);
        if (bus.s1_vld) {bus.s1_last, bus.s1_data} = s1_q[0];
        else            {bus.s1_last, bus.s1_data} = 9'h000;
        bus.out_rdy = toggle_rdy ? (cyc_n % 2 == 0) : 1'b1;
    endtask

    // One clock cycle: sample just after the inputs settle, well before the edge.
    task automatic cyc();
        #1;
        if (bus.out_vld && bus.out_rdy) begin
            if (first_x < 0) first_x = cyc_n;
            last_x = cyc_n;
            out_q.push_back(bus.out_data);
        end
        if (stall_prev && bus.out_vld) check("stall_stable", bus.out_data, stall_data);
        stall_prev = bus.out_vld && !bus.out_rdy;
        stall_data = bus.out_data;
        if (bus.abort) abort_n++;
        if (bus.s0_rdy || bus.s1_rdy)
            check("rdy_owner", {30'd0, {bus.s1_rdy, bus.s0_rdy} & ~bus.grant}, 32'd0);
        if (bus.grant != 2'b00 && grant_prev == 2'b00) grant_q.push_back(bus.grant);
        grant_prev = bus.grant;
        if (bus.s0_vld && bus.s0_rdy) void'(s0_q.pop_front());
        if (bus.s1_vld && bus.s1_rdy) void'(s1_q.pop_front());
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            cyc();
        end
    endtask

    task automatic clear_obs();
        out_q.delete();
        grant_q.delete();
        abort_n    = 0;
        first_x    = -1;
        last_x     = -1;
        cyc_n      = 0;
        stall_prev = 1'b0;
        grant_prev = 2'b00;
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, out_q.size(), exp_q.size());
        foreach (exp_q[i])
            check(tag, (i < out_q.size()) ? {24'd0, out_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    endtask

    task automatic check_grants(input string tag);
        check({tag, "_len"}, grant_q.size(), exp_g.size());
        foreach (exp_g[i])
            check(tag, (i < grant_q.size()) ? {30'd0, grant_q[i]} : 32'hFFFF_FFFF, {30'd0, exp_g[i]});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_vld"},  bus.out_vld,  32'd0);
        check({tag, "_out_data"}, bus.out_data, 32'd0);
        check({tag, "_grant"},    bus.grant,    32'd0);
        check({tag, "_abort"},    bus.abort,    32'd0);
        check({tag, "_s0_rdy"},   bus.s0_rdy,   32'd0);
        check({tag, "_s1_rdy"},   bus.s1_rdy,   32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        toggle_rdy = 1'b0;
        clear_obs();
        drive();
        @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Both sources request one-byte frames from reset: source 0 wins the tie.
        clear_obs();
        s0_q.push_back({1'b1, 8'h11});
        s1_q.push_back({1'b1, 8'h22});
        run(10);
        exp_q = '{8'h30, 8'h11, 8'h0A, 8'h31, 8'h22, 8'h0A};
        check_stream("tie_stream");
        exp_g = '{2'b01, 2'b10};
        check_grants("tie_grants");
        check("tie_first_xfer", first_x, 32'd1);
        check("tie_abort", abort_n, 32'd0);

        // Three-byte frame at full rate: five consecutive output cycles.
        clear_obs();
        s0_q.push_back({1'b0, 8'hAA});
        s0_q.push_back({1'b0, 8'hBB});
        s0_q.push_back({1'b1, 8'hCC});
        run(10);
        exp_q = '{8'h30, 8'hAA, 8'hBB, 8'hCC, 8'h0A};
        check_stream("s0_3b_stream");
        exp_g = '{2'b01};
        check_grants("s0_3b_grants");
        check("s0_3b_first_xfer", first_x, 32'd1);
        check("s0_3b_span", last_x - first_x, 32'd4);
        check("s0_3b_abort", abort_n, 32'd0);

        // Source 1 stops after one byte: four idle DATA cycles abort the frame.
        clear_obs();
        s1_q.push_back({1'b0, 8'h55});
        run(12);
        exp_q = '{8'h31, 8'h55, 8'h21};
        check_stream("timeout_stream");
        check("timeout_abort_cycles", abort_n, 32'd1);
        check("timeout_grant_end", bus.grant, 32'd0);
        check("timeout_span", last_x - first_x, 32'd6);

        // Sink ready toggles every cycle; stalled bytes must hold and not age.
        clear_obs();
        toggle_rdy = 1'b1;
        s0_q.push_back({1'b0, 8'h01});
        s0_q.push_back({1'b1, 8'h02});
        run(14);
        toggle_rdy = 1'b0;
        exp_q = '{8'h30, 8'h01, 8'h02, 8'h0A};
        check_stream("stall_stream");
        check("stall_abort", abort_n, 32'd0);

        // Reset mid-frame after two of four payload bytes.
        clear_obs();
        s0_q.push_back({1'b0, 8'hC1});
        s0_q.push_back({1'b0, 8'hC2});
        s0_q.push_back({1'b0, 8'hC3});
        s0_q.push_back({1'b1, 8'hC4});
        run(4);
        check("midrst_pre_count", out_q.size(), 32'd3);
        drive();
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        s0_q.delete();
        clear_obs();
        s0_q.push_back({1'b1, 8'h77});
        s1_q.push_back({1'b1, 8'h88});
        run(10);
        exp_q = '{8'h30, 8'h77, 8'h0A, 8'h31, 8'h88, 8'h0A};
        check_stream("postrst_stream");

        // Source 0 back-to-back frames while source 1 waits: grants alternate.
        clear_obs();
        s0_q.push_back({1'b1, 8'hA1});
        s0_q.push_back({1'b1, 8'hA2});
        s0_q.push_back({1'b1, 8'hA3});
        s1_q.push_back({1'b1, 8'hB1});
        run(20);
        exp_q = '{8'h30, 8'hA1, 8'h0A, 8'h31, 8'hB1, 8'h0A,
                  8'h30, 8'hA2, 8'h0A, 8'h30, 8'hA3, 8'h0A};
        check_stream("rr_stream");
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b01};
        check_grants("rr_grants");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
